// File: rtl/memory_stage.sv
// memory_stage: memory-access pipeline stage of the 22-bit core.
//
// Latches execute-stage results in an EX/MEM register, performs the data-memory
// access over a req/ready handshake while stalling upstream, and drives the
// MEM/WB register consumed by write-back.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   alu_result_m_in              ALU result / memory address from execute
//   write_data_m_in              store data from execute
//   wa_m_in                      destination register index
//   reg_write_m                  register write enable
//   mem_write_m                  store enable
//   mem_to_reg_m                 load: write-back selects memory data
//   mem_req, mem_we              memory request / write strobe (1 = write)
//   mem_addr, mem_wdata          memory address / store data
//   mem_rdata, mem_ready         load data / request completion
//   stall_m                      freeze fetch/decode/execute
//   result_w, wa_w, reg_write_w  MEM/WB register outputs
module memory_stage #(
  parameter int unsigned WIDTH    = 22,
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    alu_result_m_in,
  input  logic [WIDTH-1:0]    write_data_m_in,
  input  logic [REG_BITS-1:0] wa_m_in,
  input  logic                reg_write_m,
  input  logic                mem_write_m,
  input  logic                mem_to_reg_m,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ready,
  output logic                stall_m,
  output logic [WIDTH-1:0]    result_w,
  output logic [REG_BITS-1:0] wa_w,
  output logic                reg_write_w
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e state_q, state_d;

  // EX/MEM latch
  logic [WIDTH-1:0]    alu_q, wdata_q;
  logic [REG_BITS-1:0] wa_q;
  logic                rw_q, mw_q, mtr_q;

  logic [WIDTH-1:0]    rdata_q;

  // MEM/WB register
  logic [WIDTH-1:0]    wb_result_q, wb_result_d;
  logic [REG_BITS-1:0] wb_wa_q, wb_wa_d;
  logic                wb_we_q, wb_we_d;

  logic mem_op;
  logic load_sel;

  assign mem_op   = mw_q | mtr_q;
  // A store takes priority over a load when both are latched.
  assign load_sel = mtr_q & ~mw_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mem_op) state_d = StReq;
      StReq:   if (mem_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: all derived from registers only, no path from inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    stall_m   = 1'b0;
    mem_addr  = alu_q;
    mem_wdata = wdata_q;
    unique case (state_q)
      StIdle: stall_m = mem_op;
      StReq: begin
        mem_req = 1'b1;
        mem_we  = mw_q;
        stall_m = 1'b1;
      end
      StDone:  stall_m = 1'b0;
      default: stall_m = 1'b0;
    endcase
  end

  // EX/MEM latch: captures whenever the stage is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= '0;
      wdata_q <= '0;
      wa_q    <= '0;
      rw_q    <= 1'b0;
      mw_q    <= 1'b0;
      mtr_q   <= 1'b0;
    end else if (!stall_m) begin
      alu_q   <= alu_result_m_in;
      wdata_q <= write_data_m_in;
      wa_q    <= wa_m_in;
      rw_q    <= reg_write_m;
      mw_q    <= mem_write_m;
      mtr_q   <= mem_to_reg_m;
    end
  end

  // Load data capture on the completing REQ edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state_q == StReq && mem_ready) begin
      rdata_q <= mem_rdata;
    end
  end

  // MEM/WB next value: bubble (write enable low) unless the latched entry retires.
  always_comb begin
    wb_result_d = wb_result_q;
    wb_wa_d     = wb_wa_q;
    wb_we_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!mem_op) begin
          wb_result_d = alu_q;
          wb_wa_d     = wa_q;
          wb_we_d     = rw_q;
        end
      end
      StDone: begin
        wb_result_d = load_sel ? rdata_q : alu_q;
        wb_wa_d     = wa_q;
        wb_we_d     = rw_q;
      end
      default: wb_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_result_q <= '0;
      wb_wa_q     <= '0;
      wb_we_q     <= 1'b0;
    end else begin
      wb_result_q <= wb_result_d;
      wb_wa_q     <= wb_wa_d;
      wb_we_q     <= wb_we_d;
    end
  end

  assign result_w    = wb_result_q;
  assign wa_w        = wb_wa_q;
  assign reg_write_w = wb_we_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage of the 22-bit core.
- Latches execute-stage outputs in an EX/MEM register and performs the data-memory access over a req/ready handshake.
- Stalls upstream stages while an access is outstanding.
- Drives the MEM/WB register consumed by write-back.

Parameters:
WIDTH, 22, data/address width
REG_BITS, 4, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
alu_result_m_in  in  WIDTH  ALU result / address from execute
write_data_m_in  in  WIDTH  store data from execute
wa_m_in  in  REG_BITS  destination register
reg_write_m  in  1  register write enable (already condition-gated by execute)
mem_write_m  in  1  store enable (already condition-gated)
mem_to_reg_m  in  1  load: write-back selects memory data
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  store data
mem_rdata  in  WIDTH  load data, valid when mem_ready=1
mem_ready  in  1  memory completes the current request
stall_m  out  1  freeze fetch/decode/execute and hold their outputs
result_w  out  WIDTH  write-back value
wa_w  out  REG_BITS  write-back register
reg_write_w  out  1  write-back enable

Behaviour:
- Reset (async, active-high): clear EX/MEM latch, rdata_q and MEM/WB to 0, and set FSM to IDLE. mem_req, mem_we, stall_m, reg_write_w, result_w and wa_w all read 0 immediately, with no clock edge needed.
- EX/MEM latch:
  - Captures all *_m inputs on a rising edge when stall_m=0.
  - Holds when stall_m=1.
  - mem_op = latched mem_write | latched mem_to_reg.
  - If both mem_write and mem_to_reg are latched, the store wins. mem_to_reg is treated as 0 and result_w = ALU result.
- FSM states are IDLE, REQ and DONE:
  - IDLE, latched entry not mem_op:
    - stall_m=0.
    - Next edge: MEM/WB takes result_w=alu_result, wa_w and reg_write_w from the latch.
    - Stay in IDLE.
  - IDLE, latched mem_op:
    - stall_m=1; MEM/WB takes a bubble (reg_write_w=0).
    - Go to REQ.
  - REQ:
    - Drive mem_req=1, mem_we=latched mem_write, mem_addr=latched alu_result, mem_wdata=latched write_data.
    - Outputs come directly from the latch/state registers, with no combinational path from inputs.
    - stall_m=1; MEM/WB takes a bubble each cycle.
    - On an edge with mem_ready=1: rdata_q <= mem_rdata, go to DONE.
    - Otherwise stay in REQ. There is no timeout.
  - DONE:
    - mem_req=0, stall_m=0.
    - Next edge: MEM/WB takes result_w = mem_to_reg ? rdata_q : alu_result, plus wa_w and reg_write_w. The EX/MEM latch captures the next entry.
    - Go to IDLE.
- Latency:
  - Non-memory op: 1 cycle in stage.
  - Memory op: 3 + N cycles, where N = REQ cycles with mem_ready=0 before the completing edge.
  - stall_m stays asserted for 2 + N cycles.
- mem_ready is ignored outside REQ.
- Request attributes (addr, wdata, we) stay stable for the whole REQ interval.
- mem_req is never asserted in two consecutive accesses without an intervening low cycle (DONE).
- Upstream must hold its outputs while stall_m=1. No instruction may be lost or duplicated across a stall.
- Reset asserted in REQ: the request is aborted, mem_req drops asynchronously, and no write-back occurs.
- Bubble entry (all enables 0): passes through as reg_write_w=0 with no memory access.

Test Plan:
- Reset: assert rst mid-operation -> mem_req, stall_m, reg_write_w, result_w and wa_w all read 0 before the next clk edge; FSM returns to IDLE.
- ALU op: alu_result=22'h00ABC, wa=3, reg_write=1 -> stall_m stays 0. Two edges after the input is applied: result_w=22'h00ABC, wa_w=3, reg_write_w=1.
- Load with 2 wait cycles: addr=22'h000010, mem_to_reg=1, wa=5, mem_rdata=22'h15A5A, mem_ready high on the 3rd REQ cycle -> mem_req high for 3 cycles with mem_we=0 and mem_addr=22'h000010; stall_m high for 4 cycles; then result_w=22'h15A5A, wa_w=5, reg_write_w=1.
- Store, immediate ready: mem_write=1, addr=22'h3FFFFF, wdata=22'h2AAAAA -> one REQ cycle with mem_we=1 and mem_wdata=22'h2AAAAA; reg_write_w=0 throughout.
- Load then ALU op back-to-back, upstream holding the ALU op while stalled -> reg_write_w=0 during the stall, then exactly one load write-back followed by exactly one ALU write-back; mem_req low for at least one cycle between accesses.
- rst pulsed in 2nd REQ cycle with mem_ready=0 -> mem_req falls immediately; after reset release, no write-back of the aborted load occurs.
